// File: rtl/imem_boot_responder_pkg.sv
// ============================================================================
// Module : imem_boot_responder_pkg
// Brief  : Shared constants and types for the boot-loaded instruction memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_boot_responder_pkg;

    // Byte-swapped NOP (addi x0,x0,0) as the core expects it on IR.
    localparam logic [31:0] NOP_FETCH = 32'h13000000;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic [1:0] lane_t;

    localparam lane_t LANE_LAST = 2'd3;

endpackage

`default_nettype wire

// File: rtl/imem_boot_responder_byte_packer.sv
// ============================================================================
// Module : imem_boot_responder_byte_packer
// Brief  : Packs loader bytes into fetch-order words, zero-pads on last byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_boot_responder_byte_packer
    import imem_boot_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_i,
    input  logic [7:0]  data_i,
    input  logic        last_i,
    output logic [31:0] word_o,
    output logic        commit_o
);

    lane_t       lane_q, lane_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        case (lane_q)
            2'd0:    word_d[31:24] = data_i;
            2'd1:    word_d[23:16] = data_i;
            2'd2:    word_d[15:8]  = data_i;
            default: word_d[7:0]   = data_i;
        endcase
        // Lanes after the final byte still hold the previous word's bytes.
        if (last_i) begin
            case (lane_q)
                2'd0:    word_d[23:0] = 24'h000000;
                2'd1:    word_d[15:0] = 16'h0000;
                2'd2:    word_d[7:0]  = 8'h00;
                default: ;
            endcase
        end
        if (accept_i) begin
            lane_d = last_i ? 2'd0 : lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_q <= 2'd0;
            word_q <= 32'h0;
        end else if (accept_i) begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

    assign word_o   = word_d;
    assign commit_o = accept_i && ((lane_q == LANE_LAST) || last_i);

endmodule

`default_nettype wire

// File: rtl/imem_boot_responder.sv
// ============================================================================
// Module : imem_boot_responder
// Brief  : Loads a program from a byte stream after reset, then serves fetches.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_boot_responder
    import imem_boot_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    input  logic [31:0]       IR_addr,
    output logic [31:0]       IR,
    output logic              I_ready,
    output logic [ADDR_W:0]   word_count,
    output logic              ovf
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_full;
    logic              w_commit;
    logic [31:0]       w_word;
    logic              w_write;
    logic [ADDR_W-1:0] w_index;
    logic              w_hit;
    logic              w_unused_addr;

    assign ld_ready = (state_q == ST_LOAD);
    assign I_ready  = (state_q == ST_RUN);
    assign w_accept = ld_valid && ld_ready;
    assign w_full   = (word_count_q == C_DEPTH);
    assign w_write  = w_commit && !w_full;

    imem_boot_responder_byte_packer u_byte_packer (
        .clk      (clk),
        .rst      (rst),
        .accept_i (w_accept),
        .data_i   (ld_data),
        .last_i   (ld_last),
        .word_o   (w_word),
        .commit_o (w_commit)
    );

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        ovf_d        = ovf_q;
        if (w_accept) begin
            if (w_full) begin
                ovf_d = 1'b1;
            end
            if (w_write) begin
                word_count_d = word_count_q + 1'b1;
            end
            if (ld_last) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_LOAD;
            word_count_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            ovf_q        <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            mem[word_count_q[ADDR_W-1:0]] <= w_word;
        end
    end

    // Byte offset within a word is irrelevant to a word-aligned fetch.
    assign w_unused_addr = ^IR_addr[1:0];
    assign w_index       = IR_addr[ADDR_W+1:2];
    assign w_hit         = (state_q == ST_RUN)
                        && (IR_addr[31:ADDR_W+2] == '0)
                        && ({1'b0, w_index} < word_count_q);
    assign IR            = w_hit ? mem[w_index] : NOP_FETCH;

    assign word_count = word_count_q;
    assign ovf        = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_responder.sv
// ============================================================================
// Module : tb_imem_boot_responder
// Brief  : Scoreboard bench: byte-list reference model vs. boot responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_responder;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam logic [31:0] NOP = 32'h13000000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [7:0]    ld_data = 8'h00;
    logic          ld_last = 1'b0;
    logic [31:0]   IR_addr = 32'h0;
    logic [31:0]   IR;
    logic          I_ready;
    logic [AW:0]   word_count;
    logic          ovf;

    imem_boot_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .IR_addr    (IR_addr),
        .IR         (IR),
        .I_ready    (I_ready),
        .word_count (word_count),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    // kind: 0=IR 1=word_count 2=ovf 3=I_ready 4=ld_ready
    typedef struct {
        int          kind;
        logic [31:0] exp;
        logic [31:0] addr;
    } exp_t;

    exp_t   sbq[$];
    logic   sample_req = 1'b0;
    int     n_tests = 0;
    int     n_fail  = 0;

    logic [7:0] model_bytes[$];
    bit         model_run = 0;
    logic [7:0] stim[$];

    function automatic int model_stored_bytes();
        return (model_bytes.size() < 4*DEPTH) ? model_bytes.size() : 4*DEPTH;
    endfunction

    function automatic int model_count();
        int nb = model_stored_bytes();
        return model_run ? (nb + 3) / 4 : nb / 4;
    endfunction

    function automatic logic [31:0] model_ir(logic [31:0] addr);
        logic [31:0] w = 32'h0;
        int idx;
        if (!model_run || (addr >> (AW + 2)) != 0) return NOP;
        idx = int'(addr[AW+1:2]);
        if (idx >= model_count()) return NOP;
        for (int k = 0; k < 4; k++)
            if (4*idx + k < model_stored_bytes())
                w[31 - 8*k -: 8] = model_bytes[4*idx + k];
        return w;
    endfunction

    function automatic string kind_name(int k);
        case (k)
            0: return "IR";
            1: return "word_count";
            2: return "ovf";
            3: return "I_ready";
            default: return "ld_ready";
        endcase
    endfunction

    always @(negedge clk) begin
        if (sample_req) begin
            while (sbq.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = sbq.pop_front();
                case (e.kind)
                    0: act = IR;
                    1: act = 32'(word_count);
                    2: act = 32'(ovf);
                    3: act = 32'(I_ready);
                    default: act = 32'(ld_ready);
                endcase
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s addr=%h actual=%h expected=%h at %0t",
                             kind_name(e.kind), e.addr, act, e.exp, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
    endtask

    task automatic expect_status();
        sbq.push_back('{1, 32'(model_count()), 32'h0});
        sbq.push_back('{2, 32'(model_bytes.size() > 4*DEPTH), 32'h0});
        sbq.push_back('{3, 32'(model_run), 32'h0});
        sbq.push_back('{4, 32'(!model_run), 32'h0});
        sample();
    endtask

    task automatic expect_ir(input logic [31:0] addr);
        IR_addr = addr;
        sbq.push_back('{0, model_ir(addr), addr});
        sample();
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();
        rst = 1'b1;
        model_bytes.delete();
        model_run = 0;
    endtask

    task automatic drive_stream(input bit gaps, input bit with_last);
        for (int i = 0; i < stim.size(); i++) begin
            if (gaps && ((i % 2) == 1 || $urandom_range(0, 3) == 0)) begin
                ld_valid = 1'b0;
                ld_data  = 8'($urandom);
                ld_last  = 1'($urandom);
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = stim[i];
            ld_last  = with_last && (i == stim.size() - 1);
            tick();
            if (!model_run) begin
                model_bytes.push_back(stim[i]);
                if (with_last && (i == stim.size() - 1)) model_run = 1;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        do_reset();
        expect_status();
        expect_ir(32'h0);

        // Single word, fully filled on last.
        stim = '{8'h13, 8'h05, 8'h00, 8'h00};
        drive_stream(0, 1);
        expect_status();
        expect_ir(32'h0);
        n_tests++;
        if (IR !== 32'h13050000) begin
            n_fail++;
            $display("FAIL direct IR actual=%h expected=13050000 at %0t", IR, $time);
        end
        n_tests++;
        if (word_count !== 4'd1) begin
            n_fail++;
            $display("FAIL direct word_count actual=%0d expected=1 at %0t", word_count, $time);
        end
        n_tests++;
        if (I_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL direct I_ready actual=%b expected=1 at %0t", I_ready, $time);
        end
        expect_ir(32'h4);

        // Partial second word is zero padded.
        do_reset();
        stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        drive_stream(0, 1);
        expect_status();
        expect_ir(32'h0);
        expect_ir(32'h5);
        expect_ir(32'h8);

        // Overflow beyond capacity.
        do_reset();
        stim.delete();
        for (int i = 0; i < 4*DEPTH + 4; i++) stim.push_back(8'(i + 8'h40));
        drive_stream(0, 1);
        expect_status();
        expect_ir(32'(4*DEPTH - 4));
        expect_ir(32'(4*DEPTH));
        expect_ir(32'h0);

        // Reset mid-load, then reload.
        do_reset();
        stim = '{8'hDE, 8'hAD, 8'hBE};
        drive_stream(0, 0);
        expect_status();
        do_reset();
        expect_status();
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        drive_stream(0, 1);
        expect_status();
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL direct ovf actual=%b expected=0 at %0t", ovf, $time);
        end
        expect_ir(32'h0);

        // Loader activity in RUN is ignored.
        stim = '{8'hFF, 8'hEE, 8'hDD};
        drive_stream(0, 1);
        expect_status();
        expect_ir(32'h0);
        expect_ir(32'h4);

        // Gapped stream must match back-to-back content.
        do_reset();
        stim = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        drive_stream(1, 1);
        expect_status();
        expect_ir(32'h0);
        expect_ir(32'h4);
        expect_ir(32'h8);

        // Randomised loads and fetches.
        for (int it = 0; it < 12; it++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 4*DEPTH + 6);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
            drive_stream(1'($urandom), 1);
            expect_status();
            for (int r = 0; r < 8; r++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 5) == 0) ? $urandom
                                               : 32'($urandom_range(0, 4*DEPTH + 8));
                expect_ir(a);
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_fail == 0) $display("PASS");
        else             $display("FAIL");
        $finish;
    end

endmodule

`default_nettype wire
